sprite_blitter: RTL and testbench

//  Consumer end of the sprite-read path. On a start pulse, walks a SPRITE_X x SPRITE_Y sprite in raster order.

---
 rtl/vga_pkg.sv | 17 +
 rtl/sprite_blitter_addr_gen.sv | 42 ++++
 rtl/sprite_blitter.sv | 128 ++++++++++++
 tb/tb_sprite_blitter.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Constants and state encoding shared by the VGA write-path blocks.
package vga_pkg;

    localparam int COLOR_WIDTH    = 3;
    localparam int SCREEN_X       = 160;
    localparam int SCREEN_Y       = 120;
    localparam int SCREEN_WIDTH_X = 8;
    localparam int SCREEN_WIDTH_Y = 7;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } blit_state_e;

endpackage

// File: rtl/sprite_blitter_addr_gen.sv
// Raster-order sprite address counter: clear to (0,0), step x then y, flag the last address.
module blit_addr_gen #(
    parameter int WIDTH_X  = 4,
    parameter int WIDTH_Y  = 3,
    parameter int SPRITE_X = 10,
    parameter int SPRITE_Y = 6
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               clear,
    input  logic               step,
    output logic [WIDTH_X-1:0] sprite_x,
    output logic [WIDTH_Y-1:0] sprite_y,
    output logic               last
);

    localparam logic [WIDTH_X-1:0] X_LAST = WIDTH_X'(SPRITE_X - 1);
    localparam logic [WIDTH_Y-1:0] Y_LAST = WIDTH_Y'(SPRITE_Y - 1);

    logic row_end;

    assign row_end = (sprite_x == X_LAST);
    assign last    = row_end && (sprite_y == Y_LAST);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sprite_x <= '0;
            sprite_y <= '0;
        end else if (clear) begin
            sprite_x <= '0;
            sprite_y <= '0;
        end else if (step) begin
            if (row_end) begin
                sprite_x <= '0;
                sprite_y <= sprite_y + 1'b1;
            end else begin
                sprite_x <= sprite_x + 1'b1;
            end
        end
    end

endmodule

// File: rtl/sprite_blitter.sv
// Sprite blitter: walks the sprite RAM, offsets by a latched screen position and emits clipped VGA writes.
// Optional build macro SPRITE_BLITTER_TRANSPARENCY_EN skips pixels whose colour equals TRANSPARENT_COLOR.
module sprite_blitter #(
    parameter int WIDTH_X        = 4,
    parameter int WIDTH_Y        = 3,
    parameter int SPRITE_X       = 10,
    parameter int SPRITE_Y       = 6,
    parameter int SCREEN_WIDTH_X = vga_pkg::SCREEN_WIDTH_X,
    parameter int SCREEN_WIDTH_Y = vga_pkg::SCREEN_WIDTH_Y,
    parameter int SCREEN_X       = vga_pkg::SCREEN_X,
    parameter int SCREEN_Y       = vga_pkg::SCREEN_Y,
    parameter int COLOR_WIDTH    = vga_pkg::COLOR_WIDTH
`ifdef SPRITE_BLITTER_TRANSPARENCY_EN
    ,
    parameter logic [COLOR_WIDTH-1:0] TRANSPARENT_COLOR = '0
`endif
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic                      start,
    input  logic [SCREEN_WIDTH_X-1:0] pos_x,
    input  logic [SCREEN_WIDTH_Y-1:0] pos_y,
    output logic                      busy,
    output logic                      done,
    output logic [WIDTH_X-1:0]        sprite_x,
    output logic [WIDTH_Y-1:0]        sprite_y,
    input  logic [COLOR_WIDTH-1:0]    color_in,
    output logic [SCREEN_WIDTH_X-1:0] vga_x,
    output logic [SCREEN_WIDTH_Y-1:0] vga_y,
    output logic [COLOR_WIDTH-1:0]    vga_colour,
    output logic                      vga_plot
);

    import vga_pkg::*;

    localparam logic [SCREEN_WIDTH_X:0] X_LIM = SCREEN_X[SCREEN_WIDTH_X:0];
    localparam logic [SCREEN_WIDTH_Y:0] Y_LIM = SCREEN_Y[SCREEN_WIDTH_Y:0];

    blit_state_e state, state_nxt;

    logic [SCREEN_WIDTH_X-1:0] pos_x_q;
    logic [SCREEN_WIDTH_Y-1:0] pos_y_q;
    logic                      valid_d;
    logic [WIDTH_X-1:0]        sx_d;
    logic [WIDTH_Y-1:0]        sy_d;
    logic                      addr_clear;
    logic                      addr_step;
    logic                      addr_last;
    logic [SCREEN_WIDTH_X:0]   sum_x;
    logic [SCREEN_WIDTH_Y:0]   sum_y;
    logic                      on_screen;

    blit_addr_gen #(
        .WIDTH_X  (WIDTH_X),
        .WIDTH_Y  (WIDTH_Y),
        .SPRITE_X (SPRITE_X),
        .SPRITE_Y (SPRITE_Y)
    ) u_addr_gen (
        .clk      (clk),
        .resetn   (resetn),
        .clear    (addr_clear),
        .step     (addr_step),
        .sprite_x (sprite_x),
        .sprite_y (sprite_y),
        .last     (addr_last)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state   <= IDLE;
            pos_x_q <= '0;
            pos_y_q <= '0;
            valid_d <= 1'b0;
            sx_d    <= '0;
            sy_d    <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && start) begin
                pos_x_q <= pos_x;
                pos_y_q <= pos_y;
            end
            // Address issued this cycle returns from the RAM next cycle.
            valid_d <= (state == RUN);
            sx_d    <= sprite_x;
            sy_d    <= sprite_y;
        end
    end

    always_comb begin
        state_nxt  = state;
        addr_clear = 1'b0;
        addr_step  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    addr_clear = 1'b1;
                    state_nxt  = RUN;
                end
            end
            RUN: begin
                if (addr_last) state_nxt = DRAIN;
                else           addr_step = 1'b1;
            end
            DRAIN:   state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);

    // One extra bit so positions near the right/bottom edge clip instead of wrapping.
    assign sum_x     = {1'b0, pos_x_q} + {{(SCREEN_WIDTH_X + 1 - WIDTH_X){1'b0}}, sx_d};
    assign sum_y     = {1'b0, pos_y_q} + {{(SCREEN_WIDTH_Y + 1 - WIDTH_Y){1'b0}}, sy_d};
    assign on_screen = (sum_x < X_LIM) && (sum_y < Y_LIM);

    assign vga_x      = sum_x[SCREEN_WIDTH_X-1:0];
    assign vga_y      = sum_y[SCREEN_WIDTH_Y-1:0];
    assign vga_colour = color_in;

`ifdef SPRITE_BLITTER_TRANSPARENCY_EN
    assign vga_plot = valid_d && on_screen && (color_in != TRANSPARENT_COLOR);
`else
    assign vga_plot = valid_d && on_screen;
`endif

endmodule

// File: tb/tb_sprite_blitter.sv
// Bench for sprite_blitter with a 4x2 sprite, a 1-cycle-latency RAM model and a pixel-list reference model.
module tb_sprite_blitter;

    localparam int SX = 4;
    localparam int SY = 2;
    localparam int N  = SX * SY;
    localparam int TC = 0;

    logic       clk = 1'b0;
    logic       resetn;
    logic       start;
    logic [7:0] pos_x;
    logic [6:0] pos_y;
    logic       busy, done;
    logic [3:0] sprite_x;
    logic [2:0] sprite_y;
    logic [2:0] color_in;
    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [2:0] vga_colour;
    logic       vga_plot;

    int ram_tab [N];
    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    sprite_blitter #(
        .WIDTH_X  (4),
        .WIDTH_Y  (3),
        .SPRITE_X (SX),
        .SPRITE_Y (SY)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .start      (start),
        .pos_x      (pos_x),
        .pos_y      (pos_y),
        .busy       (busy),
        .done       (done),
        .sprite_x   (sprite_x),
        .sprite_y   (sprite_y),
        .color_in   (color_in),
        .vga_x      (vga_x),
        .vga_y      (vga_y),
        .vga_colour (vga_colour),
        .vga_plot   (vga_plot)
    );

    function automatic logic [2:0] ram_read(input logic [3:0] x, input logic [2:0] y);
        int xi = int'(x);
        int yi = int'(y);
        if (xi < SX && yi < SY) return 3'(ram_tab[yi * SX + xi]);
        return 3'd0;
    endfunction

    always @(posedge clk) color_in <= ram_read(sprite_x, sprite_y);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic fill_ram(input int mode);
        for (int i = 0; i < N; i++) begin
            case (mode)
                0:       ram_tab[i] = (i % SX) + 1;
                1:       ram_tab[i] = ((i % SX) == 2) ? 0 : (i % SX) + 1;
                default: ram_tab[i] = int'($urandom_range(0, 7));
            endcase
        end
    endtask

    // Request a draw at (px,py) and check every cycle until the block is idle again.
    task automatic run_draw(input int px, input int py, input bit hold, input bit disturb);
        int  sx, sy, col, ex, ey;
        bit  ep;
        start = 1'b1;
        pos_x = 8'(px);
        pos_y = 7'(py);
        for (int j = 0; j <= N + 2; j++) begin
            @(posedge clk);
            @(negedge clk);
            if (j == 0) begin
                chk("addr_x_first", 32'(sprite_x), 0);
                chk("addr_y_first", 32'(sprite_y), 0);
            end
            if (j >= 1 && j <= N) begin
                sx  = (j - 1) % SX;
                sy  = (j - 1) / SX;
                col = ram_tab[(j - 1)];
                ep  = (px + sx < 160) && (py + sy < 120);
`ifdef SPRITE_BLITTER_TRANSPARENCY_EN
                ep  = ep && (col != TC);
`endif
                ex  = (px + sx) % 256;
                ey  = (py + sy) % 128;
                chk("plot", 32'(vga_plot), 32'(ep));
                if (ep) begin
                    chk("vga_x", 32'(vga_x), ex);
                    chk("vga_y", 32'(vga_y), ey);
                    chk("vga_colour", 32'(vga_colour), col);
                end
            end else begin
                chk("plot_outside_run", 32'(vga_plot), 0);
            end
            if (j >= 1 && j < N) begin
                chk("addr_x", 32'(sprite_x), j % SX);
                chk("addr_y", 32'(sprite_y), j / SX);
            end
            chk("done", 32'(done), 32'(j == N + 1));
            chk("busy", 32'(busy), 32'(j <= N + 1));
            if (j < N + 2) begin
                if (hold)         start = 1'b1;
                else if (disturb) start = 1'($urandom_range(0, 1));
                else              start = 1'b0;
                if (disturb) begin
                    pos_x = 8'($urandom);
                    pos_y = 7'($urandom);
                end
            end else begin
                start = hold;
            end
        end
    endtask

    initial begin
        int px, py;
        resetn = 1'b0;
        start  = 1'b0;
        pos_x  = '0;
        pos_y  = '0;
        #2;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_plot", 32'(vga_plot), 0);
        chk("rst_sprite_x", 32'(sprite_x), 0);
        chk("rst_sprite_y", 32'(sprite_y), 0);
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);

        fill_ram(0);
        run_draw(10, 20, 1'b0, 1'b0);
        run_draw(158, 119, 1'b0, 1'b0);

        run_draw(40, 50, 1'b1, 1'b0);
        run_draw(100, 7, 1'b0, 1'b1);

        start = 1'b1;
        pos_x = 8'd30;
        pos_y = 7'd40;
        for (int i = 0; i <= 4; i++) begin
            @(posedge clk);
            @(negedge clk);
            start = 1'b0;
        end
        chk("pre_reset_plot", 32'(vga_plot), 1);
        chk("pre_reset_x", 32'(vga_x), 33);
        resetn = 1'b0;
        #1;
        chk("mid_reset_plot", 32'(vga_plot), 0);
        chk("mid_reset_busy", 32'(busy), 0);
        chk("mid_reset_done", 32'(done), 0);
        chk("mid_reset_sprite_x", 32'(sprite_x), 0);
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        run_draw(0, 0, 1'b0, 1'b0);

        fill_ram(1);
        run_draw(10, 20, 1'b0, 1'b0);

        for (int r = 0; r < 16; r++) begin
            fill_ram(2);
            case ($urandom_range(0, 2))
                0: begin px = int'($urandom_range(150, 255)); py = int'($urandom_range(110, 127)); end
                1: begin px = int'($urandom_range(0, 155));   py = int'($urandom_range(0, 117));   end
                default: begin px = int'($urandom_range(0, 255)); py = int'($urandom_range(0, 127)); end
            endcase
            run_draw(px, py, 1'b0, 1'($urandom_range(0, 1)));
        end

        repeat (3) @(negedge clk);
        chk("final_idle", 32'(busy), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
